// File: rtl/otp_pkg.sv
`default_nettype none
// ============================================================================
// otp_pkg : FSM states and first-fault cause codes for the OTP macro model
// Rev 1.0
// ============================================================================
package otp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_PROG  = 3'd2,
    S_READ  = 3'd3,
    S_FAULT = 3'd4
  } otp_state_e;

  typedef logic [3:0] otp_err_t;

  localparam otp_err_t ERR_NONE     = 4'd0;
  localparam otp_err_t ERR_CS_SU    = 4'd1;
  localparam otp_err_t ERR_NOVPP    = 4'd2;
  localparam otp_err_t ERR_PG_WIDTH = 4'd3;
  localparam otp_err_t ERR_RD_WIDTH = 4'd4;
  localparam otp_err_t ERR_ADR_SU   = 4'd5;
  localparam otp_err_t ERR_ADR_CHG  = 4'd6;
  localparam otp_err_t ERR_CS_ABORT = 4'd7;
  localparam otp_err_t ERR_TIMEOUT  = 4'd8;
  localparam otp_err_t ERR_OVERLAP  = 4'd9;

endpackage
`default_nettype wire

// File: rtl/otp_edge_sync.sv
`default_nettype none
// ============================================================================
// otp_edge_sync : 3-flop synchroniser with rise/fall detect on the 2nd/3rd taps
// Rev 1.0
// ============================================================================
module otp_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule
`default_nettype wire

// File: rtl/otp_macro_model.sv
`default_nettype none
// ============================================================================
// otp_macro_model : cycle model of the OTP macro with pin-timing checker and
//                   OR-only one-time-program array
// Rev 1.0
// ============================================================================
module otp_macro_model
  import otp_pkg::*;
#(
  parameter int              ADDR_W    = 7,
  parameter int              DATA_W    = 8,
  parameter int              CNT_W     = 16,
  parameter int              T_CS_SU   = 300,
  parameter int              T_ADR_SU  = 50,
  parameter int              T_RD_PW   = 100,
  parameter int              T_PG_MIN  = 10000,
  parameter int              T_PG_MAX  = 20000,
  parameter int              T_TIMEOUT = 56797,
  parameter logic [DATA_W-1:0] BLANK   = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VPP,
  input  logic              CS,
  input  logic              PROG,
  input  logic              READ,
  input  logic [ADDR_W-1:0] ADR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              ERR_CLR,
  output logic [DATA_W-1:0] DO,
  output logic              DO_VLD,
  output logic              BUSY,
  output logic              ERR,
  output logic [3:0]        ERR_CODE
);

  localparam int               c_depth   = 2**ADDR_W;
  localparam logic [CNT_W-1:0] c_cs_su   = CNT_W'(T_CS_SU);
  localparam logic [CNT_W-1:0] c_adr_su  = CNT_W'(T_ADR_SU);
  localparam logic [CNT_W-1:0] c_rd_pw   = CNT_W'(T_RD_PW);
  localparam logic [CNT_W-1:0] c_pg_min  = CNT_W'(T_PG_MIN);
  localparam logic [CNT_W-1:0] c_pg_max  = CNT_W'(T_PG_MAX);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(T_TIMEOUT);

  logic w_cs_s2,   w_cs_rise,   w_cs_fall;
  logic w_prog_s2, w_prog_rise, w_prog_fall;
  logic w_read_s2, w_read_rise, w_read_fall;

  otp_edge_sync u_sync_cs (
    .CLK(CLK), .RST(RST), .i_d(CS),
    .o_sync(w_cs_s2), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  otp_edge_sync u_sync_prog (
    .CLK(CLK), .RST(RST), .i_d(PROG),
    .o_sync(w_prog_s2), .o_rise(w_prog_rise), .o_fall(w_prog_fall)
  );
  otp_edge_sync u_sync_read (
    .CLK(CLK), .RST(RST), .i_d(READ),
    .o_sync(w_read_s2), .o_rise(w_read_rise), .o_fall(w_read_fall)
  );

  logic [ADDR_W-1:0] r_adr;
  logic [ADDR_W-1:0] r_adr_prev;
  logic              r_adr_ld;
  logic              r_adr_ld_d;
  logic              w_adr_chg;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cnt_clr;
  otp_state_e        r_state;
  otp_state_e        w_state_nxt;
  logic              w_fault;
  otp_err_t          w_fault_code;
  logic              w_prog_commit;
  logic              w_read_commit;
  logic [DATA_W-1:0] r_do;
  logic              r_do_vld;
  logic              r_err;
  otp_err_t          r_err_code;

  logic [DATA_W-1:0] r_mem [c_depth] = '{default: BLANK};

  // The first load after CS rise is a capture, not a change: only compare
  // two consecutive loads taken while CS was already high.
  assign w_adr_chg = r_adr_ld & r_adr_ld_d & (r_adr != r_adr_prev);
  assign w_cnt_clr = w_cs_rise | w_cs_fall | w_prog_rise | w_prog_fall |
                     w_read_rise | w_read_fall | w_adr_chg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_adr      <= '0;
      r_adr_prev <= '0;
      r_adr_ld   <= 1'b0;
      r_adr_ld_d <= 1'b0;
      r_cnt      <= '0;
      r_state    <= S_IDLE;
    end else begin
      if (w_cs_s2) r_adr <= ADR;
      r_adr_prev <= r_adr;
      r_adr_ld   <= w_cs_s2;
      r_adr_ld_d <= r_adr_ld;
      if (w_cnt_clr)         r_cnt <= '0;
      else if (r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
      r_state <= w_state_nxt;
    end
  end

  // Each branch chain is ordered by fault priority for its state.
  always_comb begin
    w_state_nxt   = r_state;
    w_fault       = 1'b0;
    w_fault_code  = ERR_NONE;
    w_prog_commit = 1'b0;
    w_read_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_rise) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_cs_fall) begin
          w_state_nxt = S_IDLE;
        end else if (w_prog_rise && !VPP) begin
          w_fault = 1'b1;  w_fault_code = ERR_NOVPP;
        end else if (r_cnt == c_timeout) begin
          w_state_nxt = S_IDLE;
        end else if ((w_prog_rise || w_read_rise) && (r_cnt < c_cs_su)) begin
          w_fault = 1'b1;  w_fault_code = ERR_CS_SU;
        end else if (w_adr_chg && (r_cnt < c_adr_su)) begin
          w_fault = 1'b1;  w_fault_code = ERR_ADR_SU;
        end else if (w_prog_rise) begin
          w_state_nxt = S_PROG;
        end else if (w_read_rise) begin
          w_state_nxt = S_READ;
        end
      end
      S_PROG: begin
        if (w_cs_fall) begin
          w_fault = 1'b1;  w_fault_code = ERR_CS_ABORT;
        end else if (w_adr_chg) begin
          w_fault = 1'b1;  w_fault_code = ERR_ADR_CHG;
        end else if (!VPP) begin
          w_fault = 1'b1;  w_fault_code = ERR_NOVPP;
        end else if (r_cnt == c_timeout) begin
          w_fault = 1'b1;  w_fault_code = ERR_TIMEOUT;
        end else if (w_prog_fall) begin
          if ((r_cnt >= c_pg_min) && (r_cnt <= c_pg_max)) begin
            w_prog_commit = 1'b1;
            w_state_nxt   = S_ARMED;
          end else begin
            w_fault = 1'b1;  w_fault_code = ERR_PG_WIDTH;
          end
        end
      end
      S_READ: begin
        if (w_cs_fall) begin
          w_fault = 1'b1;  w_fault_code = ERR_CS_ABORT;
        end else if (w_adr_chg) begin
          w_fault = 1'b1;  w_fault_code = ERR_ADR_CHG;
        end else if (r_cnt == c_timeout) begin
          w_fault = 1'b1;  w_fault_code = ERR_TIMEOUT;
        end else if (w_read_fall) begin
          if (r_cnt >= c_rd_pw) begin
            w_read_commit = 1'b1;
            w_state_nxt   = S_ARMED;
          end else begin
            w_fault = 1'b1;  w_fault_code = ERR_RD_WIDTH;
          end
        end
      end
      S_FAULT: begin
        if (!w_cs_s2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_prog_s2 && w_read_s2) begin
      w_fault       = 1'b1;
      w_fault_code  = ERR_OVERLAP;
      w_prog_commit = 1'b0;
      w_read_commit = 1'b0;
    end
    if (w_fault) w_state_nxt = S_FAULT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_do       <= '0;
      r_do_vld   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_do_vld <= w_read_commit;
      if (w_read_commit) r_do <= r_mem[r_adr];
      if (w_fault) begin
        r_err <= 1'b1;
        if (!r_err || ERR_CLR) r_err_code <= w_fault_code;
      end else if (ERR_CLR) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  // Array is never reset; bits can only be burned from 0 to 1.
  always_ff @(posedge CLK) begin
    if (w_prog_commit) r_mem[r_adr] <= r_mem[r_adr] | DIN;
  end

  assign DO       = r_do;
  assign DO_VLD   = r_do_vld;
  assign BUSY     = (r_state == S_PROG) || (r_state == S_READ);
  assign ERR      = r_err;
  assign ERR_CODE = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_otp_macro_model.sv
`default_nettype none
// ============================================================================
// tb_otp_macro_model : randomized bench for otp_macro_model with a
//                      transaction-level reference model of array and faults
// Rev 1.0
// ============================================================================
module tb_otp_macro_model;

  localparam int T_CS_SU   = 300;
  localparam int T_ADR_SU  = 50;
  localparam int T_RD_PW   = 100;
  localparam int T_PG_MIN  = 1000;
  localparam int T_PG_MAX  = 2000;
  localparam int T_TIMEOUT = 5000;
  localparam int SU_OK     = T_CS_SU + 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       VPP = 1'b1;
  logic       CS = 1'b0, PROG = 1'b0, READ = 1'b0, ERR_CLR = 1'b0;
  logic [6:0] ADR = '0;
  logic [7:0] DIN = '0;
  logic [7:0] DO;
  logic       DO_VLD, BUSY, ERR;
  logic [3:0] ERR_CODE;

  otp_macro_model #(
    .ADDR_W(7), .DATA_W(8), .CNT_W(16), .T_CS_SU(T_CS_SU), .T_ADR_SU(T_ADR_SU),
    .T_RD_PW(T_RD_PW), .T_PG_MIN(T_PG_MIN), .T_PG_MAX(T_PG_MAX),
    .T_TIMEOUT(T_TIMEOUT), .BLANK(8'h00)
  ) dut (
    .CLK(CLK), .RST(RST), .VPP(VPP), .CS(CS), .PROG(PROG), .READ(READ),
    .ADR(ADR), .DIN(DIN), .ERR_CLR(ERR_CLR), .DO(DO), .DO_VLD(DO_VLD),
    .BUSY(BUSY), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int vld_cycles = 0;

  always @(negedge CLK) if (DO_VLD === 1'b1) vld_cycles++;

  // Reference model state
  logic [7:0] ref_mem [128];
  logic [7:0] exp_do;
  bit         exp_err;
  int         exp_code;
  bit         sess_live;
  logic [6:0] cur_adr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic m_fault(input int code);
    if (!exp_err) exp_code = code;
    exp_err   = 1'b1;
    sess_live = 1'b0;
  endtask

  task automatic check_state(input string tag, input int v0, input int exp_vld);
    check_eq({tag, "_vld"}, vld_cycles - v0, exp_vld);
    check_eq({tag, "_do"}, DO, exp_do);
    check_eq({tag, "_err"}, ERR, exp_err);
    check_eq({tag, "_code"}, ERR_CODE, exp_code);
  endtask

  task automatic cs_on(input logic [6:0] a);
    ADR = a;  cur_adr = a;
    CS = 1'b1;
    sess_live = 1'b1;
  endtask

  task automatic cs_off();
    CS = 1'b0;
    sess_live = 1'b0;
    repeat (6) tick();
    if (exp_err) begin
      ERR_CLR = 1'b1;  tick();  ERR_CLR = 1'b0;  tick();
      exp_err = 1'b0;  exp_code = 0;
      check_eq("clr_err", ERR, 0);
      check_eq("clr_code", ERR_CODE, 0);
    end
  endtask

  task automatic set_addr(input logic [6:0] a);
    if (a != cur_adr) begin
      repeat (60) tick();
      ADR = a;  cur_adr = a;
    end
  endtask

  task automatic run_prog(input logic [6:0] a, input logic [7:0] d, input int w,
                          input bit vpp_lo, input int su);
    int v0, code;
    bit ok_start;
    set_addr(a);
    repeat (su) tick();
    v0 = vld_cycles;
    code = 0;
    ok_start = sess_live && !vpp_lo && (su - 1 >= T_CS_SU);
    if (sess_live && vpp_lo)                  code = 2;
    else if (sess_live && (su - 1 < T_CS_SU)) code = 1;
    VPP = ~vpp_lo;
    PROG = 1'b1;
    repeat (w / 2) tick();
    check_eq("prog_busy", BUSY, ok_start);
    repeat (w - w / 2) tick();
    DIN = d;
    PROG = 1'b0;
    repeat (6) tick();
    VPP = 1'b1;
    if (ok_start) begin
      if ((w - 1 >= T_PG_MIN) && (w - 1 <= T_PG_MAX)) ref_mem[a] = ref_mem[a] | d;
      else code = 3;
    end
    if (code != 0) m_fault(code);
    check_state("prog", v0, 0);
  endtask

  task automatic run_read(input logic [6:0] a, input int w, input int su);
    int v0, code, ev;
    bit ok_start;
    set_addr(a);
    repeat (su) tick();
    v0 = vld_cycles;
    ev = 0;
    ok_start = sess_live && (su - 1 >= T_CS_SU);
    code = (sess_live && !ok_start) ? 1 : 0;
    READ = 1'b1;
    repeat (w / 2) tick();
    check_eq("read_busy", BUSY, ok_start);
    repeat (w - w / 2) tick();
    READ = 1'b0;
    repeat (6) tick();
    if (ok_start) begin
      if (w - 1 >= T_RD_PW) begin
        exp_do = ref_mem[a];
        ev = 1;
      end else begin
        code = 4;
      end
    end
    if (code != 0) m_fault(code);
    check_state("read", v0, ev);
  endtask

  initial begin
    logic [6:0] a;
    int         w;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    exp_do = 8'h00;  exp_err = 1'b0;  exp_code = 0;  sess_live = 1'b0;  cur_adr = '0;

    repeat (3) tick();
    check_eq("rst_do", DO, 0);
    check_eq("rst_vld", DO_VLD, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_code", ERR_CODE, 0);
    RST = 1'b0;
    repeat (3) tick();

    // Basic burn and read-back
    cs_on(7'h05);
    run_prog(7'h05, 8'hA5, 1500, 1'b0, 400);
    run_read(7'h05, 150, SU_OK);
    cs_off();

    // Two OR-burns in one CS, then width boundaries
    cs_on(7'h15);
    run_prog(7'h15, 8'h0F, T_PG_MIN + 1, 1'b0, SU_OK);
    run_prog(7'h15, 8'hF0, T_PG_MAX + 1, 1'b0, SU_OK);
    run_read(7'h15, T_RD_PW + 1, SU_OK);
    run_read(7'h15, T_RD_PW, SU_OK);
    cs_off();

    // Short PROG: width fault, no write, later read gives nothing
    cs_on(7'h22);
    run_prog(7'h22, 8'h3C, T_PG_MIN, 1'b0, SU_OK);
    run_read(7'h22, 150, SU_OK);
    PROG = 1'b1;  repeat (20) tick();  READ = 1'b1;  repeat (6) tick();
    m_fault(9);
    check_eq("first_code", ERR_CODE, exp_code);
    READ = 1'b0;  PROG = 1'b0;  repeat (4) tick();
    cs_off();
    cs_on(7'h22);
    run_prog(7'h22, 8'h81, T_PG_MAX + 2, 1'b0, SU_OK);
    cs_off();
    cs_on(7'h22);
    run_read(7'h22, 150, SU_OK);
    cs_off();

    // CS setup and missing VPP
    cs_on(7'h05);
    run_prog(7'h05, 8'hFF, 1500, 1'b0, 100);
    cs_off();
    cs_on(7'h05);
    run_prog(7'h05, 8'hFF, 1500, 1'b1, SU_OK);
    cs_off();

    // CS dropped during READ
    cs_on(7'h05);
    repeat (SU_OK) tick();
    READ = 1'b1;  repeat (50) tick();
    CS = 1'b0;  repeat (6) tick();
    m_fault(7);
    check_state("abort", vld_cycles, 0);
    READ = 1'b0;
    cs_off();
    cs_on(7'h05);
    run_read(7'h05, 150, SU_OK);
    cs_off();

    // ADR moved during PROG, ADR change too soon after CS, overlap
    cs_on(7'h30);
    repeat (SU_OK) tick();
    PROG = 1'b1;  DIN = 8'h01;  repeat (100) tick();
    ADR = 7'h31;  cur_adr = 7'h31;  repeat (6) tick();
    m_fault(6);
    check_state("adrchg", vld_cycles, 0);
    PROG = 1'b0;
    cs_off();
    cs_on(7'h30);
    repeat (10) tick();
    ADR = 7'h32;  cur_adr = 7'h32;  repeat (6) tick();
    m_fault(5);
    check_state("adrsu", vld_cycles, 0);
    cs_off();
    cs_on(7'h30);
    repeat (SU_OK) tick();
    PROG = 1'b1;  repeat (20) tick();  READ = 1'b1;  repeat (6) tick();
    m_fault(9);
    check_state("overlap", vld_cycles, 0);
    READ = 1'b0;  PROG = 1'b0;
    cs_off();
    cs_on(7'h30);
    run_read(7'h30, 150, SU_OK);
    cs_off();

    // Reset during PROG: outputs clear, array untouched
    cs_on(7'h05);
    repeat (SU_OK) tick();
    DIN = 8'h5A;  PROG = 1'b1;
    repeat (1200) tick();
    RST = 1'b1;  #1;
    check_eq("midrst_do", DO, 0);
    check_eq("midrst_vld", DO_VLD, 0);
    check_eq("midrst_busy", BUSY, 0);
    PROG = 1'b0;  CS = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    exp_do = 8'h00;  exp_err = 1'b0;  exp_code = 0;  sess_live = 1'b0;
    repeat (3) tick();
    cs_on(7'h05);
    run_read(7'h05, 150, SU_OK);
    cs_off();

    // Idle timeout in ARMED drops to IDLE quietly
    cs_on(7'h05);
    repeat (T_TIMEOUT + 20) tick();
    sess_live = 1'b0;
    check_eq("to_err", ERR, 0);
    run_read(7'h05, 150, SU_OK);
    cs_off();

    // Randomized sessions
    for (int s = 0; s < 3; s++) begin
      cs_on(7'h10 + 7'($urandom_range(0, 3)));
      for (int k = 0; k < 4; k++) begin
        a = 7'h10 + 7'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin
          w = ($urandom_range(0, 4) == 0) ? $urandom_range(T_PG_MIN - 200, T_PG_MIN)
                                          : $urandom_range(T_PG_MIN + 1, T_PG_MIN + 300);
          run_prog(a, 8'($urandom), w, 1'b0, SU_OK);
        end else begin
          w = ($urandom_range(0, 4) == 0) ? $urandom_range(50, T_RD_PW)
                                          : $urandom_range(T_RD_PW + 1, 200);
          run_read(a, w, SU_OK);
        end
      end
      cs_off();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
